dds_sweep_sequencer: RTL and testbench

Front-end controller for the sine DDS core (18-bit tuning word, 6-bit signed sine out). It accepts frequency commands over a valid/ready port and runs a fixed tone or a timed linear frequency sweep. It converts each 9-bit frequency code Fo to the DDS tuning word with the piecewise precision correction and issues one-cycle write strobes to the DDS. It sits between the UART command decoder and the DDS instance.

---
 rtl/dds_sweep_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_dds_sweep_sequencer.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dds_sweep_sequencer.sv
// Frequency command front end for the sine DDS: fixed tones and timed linear sweeps.
// Optional macro SWEEP_LOOP_EN makes a finished sweep restart from its start code.
module dds_sweep_sequencer #(
  parameter int unsigned DWELL_CYCLES = 50000,
  parameter int unsigned DWELL_W      = 24
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_op,
  input  logic [8:0]  cmd_arg,
  output logic        dds_we,
  output logic [17:0] dds_data,
  output logic [8:0]  cur_fo,
  output logic        busy,
  output logic        sweep_done
);

  typedef enum logic [1:0] {S_IDLE, S_DWELL, S_STEP, S_FINISH} state_t;

  localparam logic [2:0] OP_FIXED = 3'd0;
  localparam logic [2:0] OP_START = 3'd1;
  localparam logic [2:0] OP_STOP  = 3'd2;
  localparam logic [2:0] OP_STEP  = 3'd3;
  localparam logic [2:0] OP_RUN   = 3'd4;
  localparam logic [2:0] OP_HALT  = 3'd5;
  localparam logic [DWELL_W-1:0] LAST_CNT = DWELL_W'(DWELL_CYCLES - 1);

  state_t r_state, w_nextState;
  logic               r_cmdValid;
  logic [2:0]         r_cmdOp;
  logic [8:0]         r_cmdArg;
  logic [8:0]         r_curFo, r_start, r_stop, r_step;
  logic [8:0]         r_actStop, r_actStep;
  logic               r_actDown;
  logic [DWELL_W-1:0] r_cnt;
  logic               r_pend, r_ddsWe, r_sweepDone;
  logic [17:0]        r_ddsData;
`ifdef SWEEP_LOOP_EN
  logic [8:0]         r_actStart;
`endif

  logic              w_loadFo, w_clrCnt, w_incCnt, w_done, w_run;
  logic [8:0]        w_nextFo, w_stepFo;
  logic [9:0]        w_upSum;
  logic signed [9:0] w_dnDiff;

  // Piecewise precision correction before scaling the code by 11.
  function automatic logic [17:0] fo2word(input logic [8:0] fo);
    logic [8:0] corr;
    if (fo >= 9'd211)     corr = 9'd2;
    else if (fo >= 9'd71) corr = 9'd1;
    else                  corr = 9'd0;
    return {9'd0, fo - corr} * 18'd11;
  endfunction

  assign cmd_ready  = ~rst;
  assign dds_we     = r_ddsWe;
  assign dds_data   = r_ddsData;
  assign cur_fo     = r_curFo;
  assign busy       = (r_state != S_IDLE);
  assign sweep_done = r_sweepDone;

  always_comb begin
    w_upSum  = {1'b0, r_curFo} + {1'b0, r_actStep};
    w_dnDiff = $signed({1'b0, r_curFo}) - $signed({1'b0, r_actStep});
    if (r_actDown)
      w_stepFo = (w_dnDiff <= $signed({1'b0, r_actStop})) ? r_actStop : w_dnDiff[8:0];
    else
      w_stepFo = (w_upSum >= {1'b0, r_actStop}) ? r_actStop : w_upSum[8:0];
  end

  always_comb begin
    w_nextState = r_state;
    w_loadFo    = 1'b0;
    w_nextFo    = r_curFo;
    w_clrCnt    = 1'b0;
    w_incCnt    = 1'b0;
    w_done      = 1'b0;
    w_run       = 1'b0;
    case (r_state)
      S_DWELL: begin
        if (r_cnt == LAST_CNT) w_nextState = (r_curFo == r_actStop) ? S_FINISH : S_STEP;
        else                   w_incCnt    = 1'b1;
      end
      S_STEP: begin
        w_nextState = S_DWELL;
        w_clrCnt    = 1'b1;
        w_loadFo    = 1'b1;
        w_nextFo    = w_stepFo;
      end
      S_FINISH: begin
        w_done = 1'b1;
`ifdef SWEEP_LOOP_EN
        w_nextState = S_DWELL;
        w_clrCnt    = 1'b1;
        w_loadFo    = 1'b1;
        w_nextFo    = r_actStart;
`else
        w_nextState = S_IDLE;
`endif
      end
      default: ;
    endcase
    // Commands applied this cycle take priority over any sweep event.
    if (r_cmdValid) begin
      case (r_cmdOp)
        OP_FIXED: begin
          w_nextState = S_IDLE;
          w_loadFo    = 1'b1;
          w_nextFo    = r_cmdArg;
          w_done      = 1'b0;
        end
        OP_RUN: begin
          w_nextState = S_DWELL;
          w_loadFo    = 1'b1;
          w_nextFo    = r_start;
          w_clrCnt    = 1'b1;
          w_run       = 1'b1;
          w_done      = 1'b0;
        end
        OP_HALT: begin
          w_nextState = S_IDLE;
          w_loadFo    = 1'b0;
          w_done      = 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_nextState;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cmdValid  <= 1'b0;
      r_cmdOp     <= 3'd0;
      r_cmdArg    <= 9'd0;
      r_curFo     <= 9'd0;
      r_start     <= 9'd0;
      r_stop      <= 9'd0;
      r_step      <= 9'd1;
      r_actStop   <= 9'd0;
      r_actStep   <= 9'd1;
      r_actDown   <= 1'b0;
      r_cnt       <= '0;
      r_pend      <= 1'b0;
      r_ddsWe     <= 1'b0;
      r_ddsData   <= 18'd0;
      r_sweepDone <= 1'b0;
`ifdef SWEEP_LOOP_EN
      r_actStart  <= 9'd0;
`endif
    end else begin
      r_cmdValid <= cmd_valid;
      r_cmdOp    <= cmd_op;
      r_cmdArg   <= cmd_arg;
      if (r_cmdValid) begin
        case (r_cmdOp)
          OP_START: r_start <= r_cmdArg;
          OP_STOP:  r_stop  <= r_cmdArg;
          OP_STEP:  r_step  <= (r_cmdArg == 9'd0) ? 9'd1 : r_cmdArg;
          default: ;
        endcase
      end
      // Sweep parameters are frozen at launch so later SET_* only affect the next run.
      if (w_run) begin
        r_actStop <= r_stop;
        r_actStep <= r_step;
        r_actDown <= (r_start > r_stop);
`ifdef SWEEP_LOOP_EN
        r_actStart <= r_start;
`endif
      end
      if (w_loadFo) r_curFo <= w_nextFo;
      if (w_clrCnt)      r_cnt <= '0;
      else if (w_incCnt) r_cnt <= r_cnt + 1'b1;
      r_pend <= w_loadFo;
      if (r_pend) r_ddsData <= fo2word(r_curFo);
      r_ddsWe     <= r_pend;
      r_sweepDone <= w_done;
    end
  end

endmodule

// File: tb/tb_dds_sweep_sequencer.sv
// Directed self-checking bench for dds_sweep_sequencer with a short dwell of 4 cycles.
module tb_dds_sweep_sequencer;

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [8:0]  cmd_arg;
  logic        dds_we;
  logic [17:0] dds_data;
  logic [8:0]  cur_fo;
  logic        busy;
  logic        sweep_done;

  int checks = 0;
  int errors = 0;
  int weCount = 0;
  int doneCount = 0;
  int seqVals[16];
  int seqLen, minHold, gotDone;
  int weBase, doneBase;

  localparam logic [2:0] OP_FIXED = 3'd0;
  localparam logic [2:0] OP_START = 3'd1;
  localparam logic [2:0] OP_STOP  = 3'd2;
  localparam logic [2:0] OP_STEP  = 3'd3;
  localparam logic [2:0] OP_RUN   = 3'd4;
  localparam logic [2:0] OP_HALT  = 3'd5;

  dds_sweep_sequencer #(.DWELL_CYCLES(4), .DWELL_W(24)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_arg(cmd_arg), .dds_we(dds_we), .dds_data(dds_data),
    .cur_fo(cur_fo), .busy(busy), .sweep_done(sweep_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse counters read the pre-edge value, so each one-cycle pulse counts once.
  always @(posedge clk) begin
    if (dds_we === 1'b1) weCount++;
    if (sweep_done === 1'b1) doneCount++;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Called on a falling edge; the command is accepted on the following rising edge.
  task automatic applyStimulus(input logic [2:0] op, input logic [8:0] arg);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_arg   = arg;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic fixedCheck(input logic [8:0] fo, input logic [17:0] word);
    int b;
    applyStimulus(OP_FIXED, fo);
    b = weCount;
    @(negedge clk);
    checkOutput("fixed cur_fo", 32'(cur_fo), 32'(fo));
    @(negedge clk);
    checkOutput("fixed dds_we high", 32'(dds_we), 32'd1);
    checkOutput("fixed dds_data", 32'(dds_data), 32'(word));
    @(negedge clk);
    checkOutput("fixed dds_we low", 32'(dds_we), 32'd0);
    checkOutput("fixed we pulses", 32'(weCount - b), 32'd1);
  endtask

  task automatic runSweep(input int budget);
    int last, hold;
    last = -1; hold = 0; seqLen = 0; minHold = 1000; gotDone = 0;
    for (int i = 0; i < budget && gotDone == 0; i++) begin
      @(negedge clk);
      if (sweep_done === 1'b1) begin
        gotDone = 1;
        if (hold < minHold) minHold = hold;
      end else if (int'(cur_fo) != last) begin
        if (last != -1 && hold < minHold) minHold = hold;
        if (seqLen < 16) seqVals[seqLen] = int'(cur_fo);
        seqLen++;
        last = int'(cur_fo);
        hold = 1;
      end else begin
        hold++;
      end
    end
    checkOutput("sweep_done seen", 32'(gotDone), 32'd1);
  endtask

  task automatic waitFo(input logic [8:0] fo, input int budget);
    int found;
    found = 0;
    for (int i = 0; i < budget && found == 0; i++) begin
      @(negedge clk);
      if (cur_fo === fo) found = 1;
    end
    checkOutput("wait for cur_fo", 32'(found), 32'd1);
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_arg = 9'd0;
    repeat (3) @(negedge clk);
    checkOutput("reset cur_fo", 32'(cur_fo), 32'd0);
    checkOutput("reset dds_data", 32'(dds_data), 32'd0);
    checkOutput("reset dds_we", 32'(dds_we), 32'd0);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset sweep_done", 32'(sweep_done), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("cmd_ready", 32'(cmd_ready), 32'd1);
    weBase = weCount;
    repeat (5) @(negedge clk);
    checkOutput("no write after reset", 32'(weCount - weBase), 32'd0);

    $display("[TB] fixed tones and word boundaries");
    fixedCheck(9'd100, 18'd1089);
    fixedCheck(9'd70,  18'd770);
    fixedCheck(9'd71,  18'd770);
    fixedCheck(9'd210, 18'd2299);
    fixedCheck(9'd211, 18'd2299);
    fixedCheck(9'd511, 18'd5599);
    fixedCheck(9'd0,   18'd0);
    fixedCheck(9'd0,   18'd0);

    $display("[TB] up sweep 10..40 step 10");
    applyStimulus(OP_START, 9'd10);
    applyStimulus(OP_STOP,  9'd40);
    applyStimulus(OP_STEP,  9'd10);
    weBase = weCount; doneBase = doneCount;
    applyStimulus(OP_RUN, 9'd0);
    @(negedge clk);
    checkOutput("sweep busy", 32'(busy), 32'd1);
    runSweep(100);
    checkOutput("up seq length", 32'(seqLen), 32'd4);
    checkOutput("up seq 0", 32'(seqVals[0]), 32'd10);
    checkOutput("up seq 1", 32'(seqVals[1]), 32'd20);
    checkOutput("up seq 2", 32'(seqVals[2]), 32'd30);
    checkOutput("up seq 3", 32'(seqVals[3]), 32'd40);
    checkOutput("up min hold >= 4", 32'(minHold >= 4), 32'd1);
    checkOutput("done busy low", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    checkOutput("up we pulses", 32'(weCount - weBase), 32'd4);
    checkOutput("up done pulses", 32'(doneCount - doneBase), 32'd1);
    checkOutput("up final cur_fo", 32'(cur_fo), 32'd40);
    checkOutput("up final word", 32'(dds_data), 32'd440);

    $display("[TB] down sweep 40..25 step 10");
    applyStimulus(OP_START, 9'd40);
    applyStimulus(OP_STOP,  9'd25);
    weBase = weCount; doneBase = doneCount;
    applyStimulus(OP_RUN, 9'd0);
    runSweep(100);
    checkOutput("down seq length", 32'(seqLen), 32'd3);
    checkOutput("down seq 0", 32'(seqVals[0]), 32'd40);
    checkOutput("down seq 1", 32'(seqVals[1]), 32'd30);
    checkOutput("down seq 2", 32'(seqVals[2]), 32'd25);
    repeat (3) @(negedge clk);
    checkOutput("down we pulses", 32'(weCount - weBase), 32'd3);
    checkOutput("down done pulses", 32'(doneCount - doneBase), 32'd1);

    $display("[TB] step argument 0 stored as 1");
    applyStimulus(OP_START, 9'd5);
    applyStimulus(OP_STOP,  9'd7);
    applyStimulus(OP_STEP,  9'd0);
    applyStimulus(OP_RUN,   9'd0);
    runSweep(100);
    checkOutput("step0 seq length", 32'(seqLen), 32'd3);
    checkOutput("step0 seq 1", 32'(seqVals[1]), 32'd6);
    checkOutput("step0 seq 2", 32'(seqVals[2]), 32'd7);

    $display("[TB] halt mid-sweep");
    applyStimulus(OP_START, 9'd10);
    applyStimulus(OP_STOP,  9'd40);
    applyStimulus(OP_STEP,  9'd10);
    applyStimulus(OP_RUN,   9'd0);
    waitFo(9'd20, 50);
    applyStimulus(OP_HALT, 9'd0);
    @(negedge clk);
    weBase = weCount; doneBase = doneCount;
    repeat (20) @(negedge clk);
    checkOutput("halt busy", 32'(busy), 32'd0);
    checkOutput("halt cur_fo", 32'(cur_fo), 32'd20);
    checkOutput("halt no done", 32'(doneCount - doneBase), 32'd0);
    checkOutput("halt no write", 32'(weCount - weBase), 32'd0);

    $display("[TB] set fixed mid-sweep");
    doneBase = doneCount;
    applyStimulus(OP_RUN, 9'd0);
    waitFo(9'd30, 50);
    applyStimulus(OP_FIXED, 9'd200);
    @(negedge clk);
    checkOutput("abort cur_fo", 32'(cur_fo), 32'd200);
    checkOutput("abort busy", 32'(busy), 32'd0);
    @(negedge clk);
    checkOutput("abort dds_we", 32'(dds_we), 32'd1);
    checkOutput("abort dds_data", 32'(dds_data), 32'd2189);
    repeat (20) @(negedge clk);
    checkOutput("abort no done", 32'(doneCount - doneBase), 32'd0);
    checkOutput("abort cur_fo held", 32'(cur_fo), 32'd200);

    $display("[TB] reset mid-sweep");
    applyStimulus(OP_RUN, 9'd0);
    waitFo(9'd20, 50);
    weBase = weCount;
    rst = 1'b1;
    @(negedge clk);
    checkOutput("rst cur_fo", 32'(cur_fo), 32'd0);
    checkOutput("rst dds_data", 32'(dds_data), 32'd0);
    checkOutput("rst dds_we", 32'(dds_we), 32'd0);
    checkOutput("rst busy", 32'(busy), 32'd0);
    checkOutput("rst sweep_done", 32'(sweep_done), 32'd0);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    checkOutput("rst no write", 32'(weCount - weBase), 32'd0);

    $display("[TB] default step after reset");
    applyStimulus(OP_START, 9'd3);
    applyStimulus(OP_STOP,  9'd5);
    applyStimulus(OP_RUN,   9'd0);
    runSweep(100);
    checkOutput("rst step seq length", 32'(seqLen), 32'd3);
    checkOutput("rst step seq 1", 32'(seqVals[1]), 32'd4);
    checkOutput("rst step seq 2", 32'(seqVals[2]), 32'd5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
